// File: rtl/rom_ctrl_seq_pkg.sv
// Shared types and helpers for the ROM integrity-check sequencer.
package rom_ctrl_seq_pkg;

  // One-hot-ish sparse encoding: every pair of states differs in at least 3 bits,
  // so a single upset can never turn one legal state into another.
  localparam int unsigned StateWidth = 6;

  typedef enum logic [StateWidth-1:0] {
    ReadLow    = 6'b101100,
    ReadHigh   = 6'b010110,
    WaitDigest = 6'b001011,
    Compare    = 6'b110001,
    Done       = 6'b011101,
    Invalid    = 6'b100010
  } state_e;

  // Address width for a memory of the given depth (at least one bit).
  function automatic int unsigned vbits(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // Position of a ROM address within the top (digest) region; the caller
  // truncates to its address width so out-of-region addresses simply wrap.
  function automatic int unsigned top_idx(input int unsigned addr,
                                          input int unsigned depth,
                                          input int unsigned top_count);
    return addr + top_count - depth;
  endfunction

endpackage

// File: rtl/rom_ctrl_digest_reg.sv
// Capture register for the expected digest words read from the top of ROM.
module rom_ctrl_digest_reg
  import rom_ctrl_seq_pkg::*;
#(
  parameter int unsigned Count = 2,
  parameter int unsigned DW    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [Count-1:0]      we_i,
  input  logic [DW-1:0]         wdata_i,
  output logic [Count*DW-1:0]   data_o
);

  logic [Count-1:0][DW-1:0] words_q;

  // Each word is written independently; word 0 occupies the low bits of data_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q <= '0;
    end else begin
      for (int i = 0; i < int'(Count); i++) begin
        if (we_i[i]) words_q[i] <= wdata_i;
      end
    end
  end

  assign data_o = words_q;

endmodule

// File: rtl/rom_ctrl_check_seq.sv
// Boot-time ROM integrity check sequencer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ReadLow    | streaming non-top ROM words to KMAC
// ReadHigh   | reading top words into the expected-digest register
// WaitDigest | ROM fully read, waiting for the KMAC digest
// Compare    | one cycle comparing expected vs computed digest
// Done       | result reported, bus owns the ROM
// Invalid    | protocol violation, fatal alert held until reset
module rom_ctrl_check_seq
  import rom_ctrl_seq_pkg::*;
#(
  parameter int unsigned RomDepth    = 16,
  parameter int unsigned RomTopCount = 2,
  parameter int unsigned DW          = 32,
  localparam int unsigned AW         = vbits(RomDepth)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        counter_done_i,
  input  logic [AW-1:0]               counter_data_addr_i,
  input  logic                        counter_last_nontop_i,
  output logic                        counter_data_rdy_o,
  input  logic                        rom_rvalid_i,
  input  logic [DW-1:0]               rom_rdata_i,
  output logic                        kmac_vld_o,
  output logic [DW-1:0]               kmac_data_o,
  output logic                        kmac_last_o,
  input  logic                        kmac_rdy_i,
  input  logic                        kmac_digest_vld_i,
  input  logic [RomTopCount*DW-1:0]   kmac_digest_i,
  output logic                        bus_sel_o,
  output logic                        pwrmgr_done_o,
  output logic                        pwrmgr_good_o,
  output logic                        alert_o
);

  state_e                    state_q, state_d;
  logic [RomTopCount*DW-1:0] kmac_q;
  logic [RomTopCount*DW-1:0] exp_flat;
  logic                      got_q;
  logic                      good_q, good_d;
  logic                      done_q, good_out_q, bus_sel_q, alert_q;
  logic [AW-1:0]             top_addr;
  logic [RomTopCount-1:0]    exp_we;
  logic                      digest_capture;

  assign top_addr = AW'(top_idx(32'(counter_data_addr_i), RomDepth, RomTopCount));

  // Only the first digest strobe while the top words are being read or awaited is kept.
  assign digest_capture = kmac_digest_vld_i && !got_q &&
                          ((state_q == ReadHigh) || (state_q == WaitDigest));

  // Route each valid top-region word to its slot in the expected digest.
  always_comb begin
    exp_we = '0;
    for (int i = 0; i < int'(RomTopCount); i++) begin
      exp_we[i] = (state_q == ReadHigh) && rom_rvalid_i && (top_addr == AW'(i));
    end
  end

  rom_ctrl_digest_reg #(
    .Count (RomTopCount),
    .DW    (DW)
  ) u_digest (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (exp_we),
    .wdata_i (rom_rdata_i),
    .data_o  (exp_flat)
  );

  // Handshake muxing: KMAC sees ROM data only while non-top words stream.
  always_comb begin
    kmac_vld_o         = 1'b0;
    kmac_data_o        = '0;
    kmac_last_o        = 1'b0;
    counter_data_rdy_o = 1'b0;
    case (state_q)
      ReadLow: begin
        kmac_vld_o         = rom_rvalid_i;
        kmac_data_o        = rom_rdata_i;
        kmac_last_o        = counter_last_nontop_i;
        counter_data_rdy_o = kmac_rdy_i;
      end
      ReadHigh: counter_data_rdy_o = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic with protocol checking; any unknown encoding falls to Invalid.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ReadLow: begin
        if (counter_done_i || kmac_digest_vld_i) begin
          state_d = Invalid;
        end else if (kmac_vld_o && kmac_rdy_i && kmac_last_o) begin
          state_d = ReadHigh;
        end
      end
      ReadHigh: begin
        if (kmac_digest_vld_i && got_q) begin
          state_d = Invalid;
        end else if (counter_done_i) begin
          state_d = (got_q || kmac_digest_vld_i) ? Compare : WaitDigest;
        end
      end
      WaitDigest: begin
        if (!counter_done_i) begin
          state_d = Invalid;
        end else if (kmac_digest_vld_i) begin
          state_d = Compare;
        end
      end
      Compare: begin
        if (!counter_done_i || kmac_digest_vld_i) begin
          state_d = Invalid;
        end else begin
          good_d  = (exp_flat == kmac_q);
          state_d = Done;
        end
      end
      Done: begin
        if (!counter_done_i || kmac_digest_vld_i) state_d = Invalid;
      end
      Invalid: state_d = Invalid;
      default: state_d = Invalid;
    endcase
  end

  // State, digest capture and glitch-free registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ReadLow;
      kmac_q     <= '0;
      got_q      <= 1'b0;
      good_q     <= 1'b0;
      done_q     <= 1'b0;
      good_out_q <= 1'b0;
      bus_sel_q  <= 1'b0;
      alert_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      if (digest_capture) begin
        kmac_q <= kmac_digest_i;
        got_q  <= 1'b1;
      end
      done_q     <= (state_d == Done);
      good_out_q <= (state_d == Done) && good_d;
      bus_sel_q  <= (state_d == Done);
      alert_q    <= (state_d == Invalid);
    end
  end

  assign pwrmgr_done_o = done_q;
  assign pwrmgr_good_o = good_out_q;
  assign bus_sel_o     = bus_sel_q;
  assign alert_o       = alert_q;

endmodule

// File: doc/rom_ctrl_check_seq.md
Name: rom_ctrl_check_seq

Overview:
- Sequencer that runs the boot-time ROM integrity check.
- Paces the ROM read counter, forwards the non-top ROM words to KMAC, and captures the top RomTopCount words as the expected digest.
- Compares the expected digest against the KMAC digest and reports the result to the power manager.
- Hands ROM ownership to the bus only after the check completes; any protocol violation latches a fatal alert.

Parameters:
- RomDepth, 16: ROM words; address width AW = vbits(RomDepth).
- RomTopCount, 2: top words holding the expected digest; 1 <= RomTopCount, RomDepth-RomTopCount >= 2.
- DW, 32: ROM data width (digest word width).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- counter_done_i  in  1  counter finished reading ROM
- counter_data_addr_i  in  AW  address of word currently on rom_rdata_i
- counter_last_nontop_i  in  1  current word is last non-top word
- counter_data_rdy_o  out  1  sequencer accepts current ROM word
- rom_rvalid_i  in  1  ROM data valid
- rom_rdata_i  in  DW  ROM data word
- kmac_vld_o  out  1  data valid to KMAC
- kmac_data_o  out  DW  data to KMAC
- kmac_last_o  out  1  final message word
- kmac_rdy_i  in  1  KMAC accepts data
- kmac_digest_vld_i  in  1  one-cycle digest strobe
- kmac_digest_i  in  RomTopCount*DW  computed digest
- bus_sel_o  out  1  1 = bus owns ROM mux
- pwrmgr_done_o  out  1  check complete
- pwrmgr_good_o  out  1  digest matched
- alert_o  out  1  fatal protocol alert (level)

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. All outputs 0, state ReadLow, digest registers and flags cleared. Reset mid-operation aborts and restarts from ReadLow; no partial result is kept.
- ReadLow:
  - kmac_vld_o = rom_rvalid_i; kmac_data_o = rom_rdata_i; counter_data_rdy_o = kmac_rdy_i; kmac_last_o = counter_last_nontop_i.
  - Handshake (vld & rdy) with kmac_last_o=1 -> ReadHigh. kmac_rdy_i low stalls the counter, with no word lost or repeated.
- ReadHigh:
  - counter_data_rdy_o = 1, kmac_vld_o = 0.
  - On rom_rvalid_i, store rom_rdata_i into exp_q[idx], idx = counter_data_addr_i - (RomDepth-RomTopCount), truncated to AW bits.
  - counter_done_i=1 -> Compare if the KMAC digest has been latched, else WaitDigest.
- WaitDigest: kmac_digest_vld_i -> latch digest, go to Compare.
- KMAC digest capture: kmac_digest_vld_i is accepted in ReadHigh or WaitDigest and latched into kmac_q with flag got_q.
- Simultaneous events: counter_done_i and kmac_digest_vld_i in the same cycle in ReadHigh -> digest latched, next state Compare.
- Compare: one cycle; good_d = (exp_q == kmac_q) full-width -> Done.
- Done: terminal.
  - pwrmgr_done_o=1, pwrmgr_good_o=good_q, bus_sel_o=1, all registered.
  - pwrmgr_done_o rises exactly 2 cycles after the later of counter_done_i and digest capture.
- Invalid: terminal until reset. alert_o=1, bus_sel_o=0, pwrmgr_done_o=0, pwrmgr_good_o=0. Entry conditions:
  - counter_done_i=1 in ReadLow;
  - kmac_digest_vld_i in ReadLow;
  - counter_done_i falls in WaitDigest/Compare/Done;
  - second kmac_digest_vld_i after capture;
  - illegal state encoding.
- State encoding: sparse (min Hamming distance 3); unknown encoding -> Invalid.
- bus_sel_o, pwrmgr_* and alert_o are driven from flops (no combinational glitches).

Decomposition:
- Package rom_ctrl_seq_pkg:
  - state_e: ReadLow, ReadHigh, WaitDigest, Compare, Done, Invalid, with sparse 6-bit values;
  - StateWidth;
  - function top_idx(addr) for the digest index.
- One sub-module, rom_ctrl_digest_reg: RomTopCount x DW capture register with per-index write enable and flattened output. The FSM, handshake muxing and compare stay in the top module.

Test Plan (RomDepth=16, RomTopCount=2, DW=32):
- Nominal: ROM words 0..13 = i, words 14/15 = A/B, kmac_rdy_i=1; digest {B,A} arrives 5 cycles after last -> 14 KMAC handshakes, last on word 13; pwrmgr_done_o=1, good=1, bus_sel_o=1.
- Mismatch: as nominal but digest {B,A^1} -> pwrmgr_done_o=1, pwrmgr_good_o=0, bus_sel_o=1, alert_o=0.
- Backpressure: kmac_rdy_i toggles 1-0-0-1 repeatedly -> counter_data_rdy_o mirrors kmac_rdy_i; KMAC receives 0..13 exactly once in order.
- Simultaneous: digest strobe in the same cycle as counter_done_i -> Done 2 cycles later, good=1.
- Protocol faults: counter_done_i forced high in ReadLow -> alert_o=1 next cycle, bus_sel_o=0. Separately, counter_done_i dropped in Done -> alert_o=1, pwrmgr_done_o=0.
- Reset mid-ReadHigh: rst_ni pulsed after word 14 -> all outputs 0, exp_q cleared; rerun completes with good=1.
